sr_ctrl: RTL and testbench

Command-driven sequencer for the 8-bit rotating pattern register on the LED/display path. Accepts load and rotate commands over a valid/ready handshake and steps the pattern at a rate set by an internal tick counter. It replaces the derived-clock prescaler arrangement: the whole block runs on the single system clock and uses a clock-enable tick. It owns the pattern register and drives it directly to the outputs.

---
 rtl/sr_ctrl.sv | 148 ++++++++++++++
 tb/tb_sr_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ctrl.sv
// Command-driven 8-bit (W-bit) rotating pattern sequencer on a single clock.
// A LOAD/ROT/NOP handshake drives a pattern register stepped by an internal clock-enable tick.
module sr_ctrl #(
  parameter int unsigned  N    = 20,
  parameter int unsigned  W    = 8,
  parameter logic [W-1:0] INIT = W'(8'h01)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_arg,
  input  logic         halt,
  output logic [W-1:0] data,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef enum logic [1:0] {
    OpLoad = 2'b00,
    OpRotL = 2'b01,
    OpRotR = 2'b10,
    OpNop  = 2'b11
  } op_e;

  state_e state_q, state_d;

  logic [W-1:0] data_q, data_d;
  logic [W-1:0] rem_q, rem_d;
  logic [N-1:0] pcnt_q, pcnt_d;
  logic         dir_q, dir_d;
  logic         done_q, done_d;

  logic         accept;
  logic         rot_op;
  logic         rot_start;
  logic         tick;
  logic         last_step;
  logic [W-1:0] rot_left;
  logic [W-1:0] rot_right;

  assign accept    = cmd_valid && (state_q == StIdle);
  assign rot_op    = (cmd_op == OpRotL) || (cmd_op == OpRotR);
  assign rot_start = accept && rot_op && (cmd_arg != '0);
  // pcnt only counts in RUN, so all-ones can never be seen while idle.
  assign tick      = (pcnt_q == '1);
  assign last_step = (rem_q == W'(1));
  assign rot_left  = {data_q[W-2:0], data_q[W-1]};
  assign rot_right = {data_q[0], data_q[W-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rot_start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (halt || (tick && last_step)) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Outputs decode the registered state only
  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q == StRun);
    data      = data_q;
    done      = done_q;
  end

  // Datapath next-state
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    dir_d  = dir_q;
    pcnt_d = '0;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (cmd_op)
            OpLoad: begin
              data_d = cmd_arg;
              done_d = 1'b1;
            end
            OpRotL, OpRotR: begin
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                rem_d = cmd_arg;
                dir_d = (cmd_op == OpRotR);
              end
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end
      StRun: begin
        // halt wins over a coincident tick: no step, no done
        if (!halt) begin
          pcnt_d = pcnt_q + N'(1);
          if (tick) begin
            data_d = dir_q ? rot_right : rot_left;
            rem_d  = rem_q - W'(1);
            done_d = last_step;
          end
        end
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= INIT;
      rem_q  <= '0;
      pcnt_q <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      rem_q  <= rem_d;
      pcnt_q <= pcnt_d;
      dir_q  <= dir_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_sr_ctrl.sv
// Bench for sr_ctrl: directed scenarios plus random commands, every cycle checked
// against a timeline model (steps = elapsed cycles / tick period).
module tb_sr_ctrl;

  localparam int unsigned N = 2;
  localparam int unsigned W = 8;
  localparam logic [W-1:0] INIT = 8'h01;
  localparam int P = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_arg;
  logic         halt;
  logic [W-1:0] data;
  logic         busy;
  logic         done;

  sr_ctrl #(.N(N), .W(W), .INIT(INIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .halt     (halt),
    .data     (data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Reference model state
  logic [W-1:0] m_data;
  logic [W-1:0] m_base;
  bit           m_busy;
  bit           m_done;
  bit           m_dir;
  int           m_t0;
  int           m_k;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [W-1:0] rot(input logic [W-1:0] b, input int s, input bit right);
    logic [2*W-1:0] x;
    logic [2*W-1:0] y;
    int r;
    r = s % W;
    x = {b, b};
    if (right) begin
      y = x >> r;
      return y[W-1:0];
    end
    y = x << r;
    return y[2*W-1:W];
  endfunction

  // Applies the inputs present at the edge just taken
  task automatic model_edge();
    int elapsed;
    int steps;
    if (rst) begin
      m_data = INIT;
      m_busy = 0;
      m_done = 0;
    end else if (m_busy) begin
      m_done  = 0;
      elapsed = edge_n - m_t0;
      if (halt) begin
        m_busy = 0;
      end else if (elapsed % P == 0) begin
        steps  = elapsed / P;
        m_data = rot(m_base, steps, m_dir);
        if (steps == m_k) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else begin
      m_done = 0;
      if (cmd_valid) begin
        if (cmd_op == 2'b00) begin
          m_data = cmd_arg;
          m_done = 1;
        end else if (cmd_op == 2'b11 || cmd_arg == '0) begin
          m_done = 1;
        end else begin
          m_busy = 1;
          m_t0   = edge_n;
          m_k    = int'(cmd_arg);
          m_base = m_data;
          m_dir  = (cmd_op == 2'b10);
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [1:0] op, input logic [W-1:0] arg,
                     input bit h, input bit r);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    halt      = h;
    rst       = r;
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check_eq("data", 32'(data), 32'(m_data));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    check_eq("done", 32'(done), 32'(m_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'b11, '0, 0, 0);
  endtask

  initial begin
    m_data = INIT;
    m_base = INIT;
    m_busy = 0;
    m_done = 0;
    m_dir  = 0;
    m_t0   = 0;
    m_k    = 0;

    // Reset
    cyc(0, 2'b11, '0, 0, 1);
    cyc(0, 2'b11, '0, 0, 1);
    check_eq("rst_data", 32'(data), 32'h01);
    check_eq("rst_ready", 32'(cmd_ready), 32'h1);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);

    // Back-to-back LOADs
    cyc(1, 2'b00, 8'hA5, 0, 0);
    check_eq("load_a5", 32'(data), 32'hA5);
    check_eq("load_a5_done", 32'(done), 32'h1);
    cyc(1, 2'b00, 8'h3C, 0, 0);
    check_eq("load_3c", 32'(data), 32'h3C);
    idle(1);
    check_eq("done_clear", 32'(done), 32'h0);

    // LOAD 0x81, ROT_LEFT 3
    cyc(1, 2'b00, 8'h81, 0, 0);
    cyc(1, 2'b01, 8'd3, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 2'b11, '0, 0, 0);
      if (i == 4) check_eq("rotl_s1", 32'(data), 32'h03);
      if (i == 8) check_eq("rotl_s2", 32'(data), 32'h06);
      if (i < 12) check_eq("rotl_busy", 32'(busy), 32'h1);
    end
    check_eq("rotl_s3", 32'(data), 32'h0C);
    check_eq("rotl_done", 32'(done), 32'h1);
    check_eq("rotl_ready", 32'(cmd_ready), 32'h1);

    // LOAD 0x96, ROT_RIGHT 8 with an ignored LOAD while busy
    cyc(1, 2'b00, 8'h96, 0, 0);
    cyc(1, 2'b10, 8'd8, 0, 0);
    for (int i = 1; i <= 32; i++) begin
      cyc(i == 5, 2'b00, 8'hFF, 0, 0);
      if (i == 5) check_eq("busy_ignore", 32'(data != 8'hFF), 32'h1);
    end
    check_eq("rotr_full", 32'(data), 32'h96);

    // Halt after one step, then halt on the tick edge
    cyc(1, 2'b00, 8'h01, 0, 0);
    cyc(1, 2'b01, 8'd5, 0, 0);
    for (int i = 1; i <= 6; i++) cyc(0, 2'b11, '0, i == 6, 0);
    check_eq("halt_data", 32'(data), 32'h02);
    check_eq("halt_ready", 32'(cmd_ready), 32'h1);
    check_eq("halt_done", 32'(done), 32'h0);
    idle(2);
    cyc(1, 2'b00, 8'h01, 0, 0);
    cyc(1, 2'b01, 8'd5, 0, 0);
    for (int i = 1; i <= 8; i++) cyc(0, 2'b11, '0, i == 8, 0);
    check_eq("halt_tick_data", 32'(data), 32'h02);
    check_eq("halt_tick_busy", 32'(busy), 32'h0);

    // Zero-count rotate and NOP
    cyc(1, 2'b01, 8'd0, 0, 0);
    check_eq("rot0_done", 32'(done), 32'h1);
    check_eq("rot0_data", 32'(data), 32'h02);
    cyc(1, 2'b11, 8'h55, 0, 0);
    check_eq("nop_done", 32'(done), 32'h1);
    check_eq("nop_busy", 32'(busy), 32'h0);

    // Reset mid-RUN
    cyc(1, 2'b10, 8'd5, 0, 0);
    idle(6);
    cyc(0, 2'b11, '0, 0, 1);
    check_eq("rst_run_data", 32'(data), 32'h01);
    check_eq("rst_run_busy", 32'(busy), 32'h0);
    check_eq("rst_run_done", 32'(done), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 1) == 1,
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)),
          $urandom_range(0, 29) == 0,
          $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
